// File: rtl/guess_sequencer.sv
// Guess sequencer: captures UART bytes, keeps letters (forced to uppercase), queues them,
// and offers them one at a time to the game FSM. Optional used-letter filter: GUESS_SEQ_DUP_FILTER_EN.
module guess_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_ready,
    input  logic             rx_err,
    input  logic             game_rdy,
    input  logic             guess_ack,
    input  logic             flush,
    output logic [7:0]       guess,
    output logic             guess_valid,
    output logic             reject,
    output logic             overflow,
    output logic             dup_reject,
    output logic [CNT_W-1:0] pending
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

    state_t             state_q, state_d;
    logic               cap_valid_q, cap_valid_d;
    logic [7:0]         cap_byte_q, cap_byte_d;
    logic               cap_err_q, cap_err_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         guess_q, guess_d;
    logic               guess_valid_q, guess_valid_d;
    logic               reject_q, reject_d;
    logic               overflow_q, overflow_d;
`ifdef GUESS_SEQ_DUP_FILTER_EN
    logic [25:0]        mask_q, mask_d;
    logic               dup_q, dup_d;
`endif

    logic       is_upper, is_lower, letter_ok, dup_hit, accept, full, pop, push;
    logic [7:0] norm, head;

    assign is_upper  = (cap_byte_q >= 8'h41) && (cap_byte_q <= 8'h5A);
    assign is_lower  = (cap_byte_q >= 8'h61) && (cap_byte_q <= 8'h7A);
    assign norm      = is_lower ? (cap_byte_q - 8'h20) : cap_byte_q;
    assign letter_ok = cap_valid_q && !cap_err_q && (is_upper || is_lower);
    assign head      = mem_q[rd_ptr_q];
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = (state_q == OFFER) && guess_ack;
`ifdef GUESS_SEQ_DUP_FILTER_EN
    // 'A'..'Z' have low five bits 1..26, so subtracting one gives the mask index.
    assign dup_hit   = letter_ok && mask_q[norm[4:0] - 5'd1];
`else
    assign dup_hit   = 1'b0;
`endif
    assign accept    = letter_ok && !dup_hit;
    // A full FIFO still takes the letter when the head leaves in the same cycle.
    assign push      = accept && (!full || pop);

    always_comb begin
        state_d       = state_q;
        cap_valid_d   = rx_ready;
        cap_byte_d    = rx_ready ? rx_byte : cap_byte_q;
        cap_err_d     = rx_ready ? rx_err : cap_err_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        guess_d       = guess_q;
        guess_valid_d = guess_valid_q;
        reject_d      = cap_valid_q && !letter_ok;
        overflow_d    = accept && full && !pop;
`ifdef GUESS_SEQ_DUP_FILTER_EN
        mask_d        = mask_q;
        dup_d         = dup_hit;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = norm;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef GUESS_SEQ_DUP_FILTER_EN
            mask_d[head[4:0] - 5'd1] = 1'b1;
`endif
        end
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);

        case (state_q)
            IDLE: begin
                guess_d       = 8'h00;
                guess_valid_d = 1'b0;
                if (count_q != '0 && game_rdy) begin
                    state_d       = OFFER;
                    guess_d       = head;
                    guess_valid_d = 1'b1;
                end
            end
            OFFER: begin
                if (guess_ack) begin
                    state_d       = GAP;
                    guess_d       = 8'h00;
                    guess_valid_d = 1'b0;
                end else if (!game_rdy) begin
                    state_d       = IDLE;
                    guess_d       = 8'h00;
                    guess_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                guess_d       = 8'h00;
                guess_valid_d = 1'b0;
            end
        endcase

        // New game: drop queue, captured byte and any pulse; wins over push/pop/ack.
        if (flush) begin
            state_d       = IDLE;
            cap_valid_d   = 1'b0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            guess_d       = 8'h00;
            guess_valid_d = 1'b0;
            reject_d      = 1'b0;
            overflow_d    = 1'b0;
            mem_d         = mem_q;
`ifdef GUESS_SEQ_DUP_FILTER_EN
            mask_d        = '0;
            dup_d         = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= IDLE;
            cap_valid_q   <= 1'b0;
            cap_byte_q    <= 8'h00;
            cap_err_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            guess_q       <= 8'h00;
            guess_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef GUESS_SEQ_DUP_FILTER_EN
            mask_q        <= '0;
            dup_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cap_valid_q   <= cap_valid_d;
            cap_byte_q    <= cap_byte_d;
            cap_err_q     <= cap_err_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            guess_q       <= guess_d;
            guess_valid_q <= guess_valid_d;
            reject_q      <= reject_d;
            overflow_q    <= overflow_d;
`ifdef GUESS_SEQ_DUP_FILTER_EN
            mask_q        <= mask_d;
            dup_q         <= dup_d;
`endif
        end
    end

    assign guess       = guess_q;
    assign guess_valid = guess_valid_q;
    assign reject      = reject_q;
    assign overflow    = overflow_q;
    assign pending     = count_q;
`ifdef GUESS_SEQ_DUP_FILTER_EN
    assign dup_reject  = dup_q;
`else
    assign dup_reject  = 1'b0;
`endif
endmodule

// File: doc/guess_sequencer.md
Name: guess_sequencer

Overview:
- Sits between the UART receiver and the game FSM. It replaces the single-byte capture stage with a sequenced, filtered guess queue.
- Each received byte is captured, classified and normalised: ASCII letters are kept, and lowercase is converted to uppercase.
- Valid letters are queued in a small FIFO.
- Queued guesses are offered one at a time to the game FSM over a valid/ack handshake, gated by game_rdy.

Parameters:
- FIFO_DEPTH, 4, number of pending guesses held; must be a power of 2 and at least 2.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the pending count.

Ports:
- clk  input  1  system clock.
- nRst  input  1  reset; asynchronous, active-low.
- rx_byte  input  8  byte from the UART receiver.
- rx_ready  input  1  one-cycle strobe; rx_byte is valid while it is high.
- rx_err  input  1  framing/parity error flag, qualified by rx_ready.
- game_rdy  input  1  game FSM is in a state that accepts guesses.
- guess_ack  input  1  game FSM consumes the offered guess this cycle.
- flush  input  1  synchronous clear of the queue (new game).
- guess  output  8  offered guess; uppercase ASCII, or 0 when not offering.
- guess_valid  output  1  guess is being offered.
- reject  output  1  one-cycle pulse: byte dropped as a non-letter or rx_err.
- overflow  output  1  one-cycle pulse: valid letter dropped because the FIFO was full.
- dup_reject  output  1  one-cycle pulse: letter already used (see Optional Feature).
- pending  output  CNT_W  number of FIFO entries.

Behaviour:
- Reset (nRst low, asynchronous):
  - All outputs go to 0.
  - The FIFO pointers and count go to 0, the capture register goes to 0, and the FSM goes to IDLE.
  - Reset asserted mid-offer discards everything.
- Capture stage:
  - rx_ready is sampled at clock edge E0; rx_byte and rx_err are registered with a capture-valid bit.
  - A new strobe on the very next cycle is also captured, so back-to-back bytes are never lost at this stage.
- Classify stage (cycle after E0, combinational from the capture register):
  - 0x41–0x5A is accepted unchanged.
  - 0x61–0x7A is accepted with 0x20 subtracted.
  - Any other byte, or rx_err=1, is dropped; reject pulses high for the cycle after E1.
- FIFO write:
  - An accepted letter is written at edge E1 if pending < FIFO_DEPTH.
  - If the FIFO is full, the letter is dropped; overflow pulses for one cycle and the contents are unchanged.
- FSM:
  - IDLE:
    - guess=0 and guess_valid=0.
    - Go to OFFER when pending != 0 and game_rdy=1.
  - OFFER:
    - guess = FIFO head and guess_valid=1, both registered.
    - On guess_ack=1: pop the head and go to GAP.
    - If game_rdy drops without ack: go to IDLE with no pop; the head is re-offered later.
  - GAP:
    - guess_valid=0 for exactly one cycle, then go to IDLE.
    - Guarantees that one ack never consumes two entries.
- Latency: with the FIFO empty and game_rdy=1, rx_ready at E0 gives a write at E1, OFFER entered at E2, and guess_valid high in the cycle after E2.
- guess_ack outside OFFER is ignored.
- Simultaneous push and pop in the same cycle: both take effect and pending is unchanged. A push is accepted even when full if a pop occurs that same cycle.
- flush:
  - Empties the FIFO and returns the FSM to IDLE (guess_valid=0 the next cycle).
  - Discards any byte in the capture stage without any pulse.
  - flush has priority over push, pop and ack in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. pending ranges 0..FIFO_DEPTH and never wraps.
- Pulse outputs (reject, overflow, dup_reject) are mutually exclusive per byte and registered.

Optional Feature:
- Macro: GUESS_SEQ_DUP_FILTER_EN.
- With the macro defined:
  - A 26-bit used-letter mask is maintained.
  - A mask bit is set when that letter is popped via guess_ack.
  - At classify, a letter whose bit is set is dropped and dup_reject pulses; it has no FIFO effect.
  - Letters still pending in the FIFO are not in the mask, so duplicates among pending letters are allowed.
  - flush and reset clear the mask.
- Without the macro: no mask exists, dup_reject is tied to 0, and all letters follow the normal path.

Test Plan:
1. Reset, then game_rdy=1 and rx_byte=0x62 ('b') with rx_ready for one cycle → guess_valid rises the cycle after E2 with guess=0x42 and pending=1; guess_ack → pending=0, one GAP cycle, guess=0.
2. Bytes 0x31, 0x5B and 0x41 with rx_err=1 → three reject pulses, pending stays 0, guess_valid never rises.
3. game_rdy=0; send 'A','B','C','D','E' back-to-back → pending=4 and one overflow pulse for 'E'; then game_rdy=1 with ack on each offer → guesses 0x41, 0x42, 0x43, 0x44 in order, each separated by a GAP cycle.
4. Offer 'Q' (0x51), then drop game_rdy before ack → guess=0, pending=1; raise game_rdy → 0x51 re-offered.
5. FIFO full, with a new letter arriving at the FIFO in the same cycle as an ack → pending stays 4, no overflow. Then assert flush together with guess_ack → pending=0 and guess_valid=0 the next cycle.
6. With GUESS_SEQ_DUP_FILTER_EN defined: ack 'A', then send 'a' → dup_reject pulse, pending=0; flush, then send 'A' → accepted. Without the macro, the same sequence accepts both and dup_reject stays 0.
